// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, operation codes and flag indices for the ALU
package alu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_ORR   = 3'b011,
        ALU_EOR   = 3'b100,
        ALU_MUL   = 3'b101,
        ALU_SMULL = 3'b110,
        ALU_UMULL = 3'b111
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/result bundle between the datapath and the ALU
// master: drives ALUControl, A, B; observes ALUFlags, Result, ResultExtra
// slave : the ALU itself
interface alu_if;
    import alu_pkg::*;

    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUFlags;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] ResultExtra;

    modport master (
        output ALUControl, A, B,
        input  ALUFlags, Result, ResultExtra
    );

    modport slave (
        input  ALUControl, A, B,
        output ALUFlags, Result, ResultExtra
    );

endinterface

// File: rtl/alu_mul64.sv
// rtl/alu_mul64.sv - combinational 33x33 signed multiplier, 64-bit product
// a, b    : operands already sign- or zero-extended to 33 bits by the caller
// product : low 64 bits of a*b (the full value of any 32x32 signed/unsigned product)
module alu_mul64 (
    input  logic signed [32:0] a,
    input  logic signed [32:0] b,
    output logic        [63:0] product
);

    logic signed [63:0] a_w;
    logic signed [63:0] b_w;

    // Widening to 64 bits up front keeps the multiply in a 64-bit context,
    // so truncation drops only bits a 32x32 product can never reach.
    assign a_w = {{31{a[32]}}, a};
    assign b_w = {{31{b[32]}}, b};
    assign product = a_w * b_w;

endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - 32-bit ALU with NZCV flags and registered outputs
// clk   : rising-edge clock
// rst_n : asynchronous active-low reset, clears all outputs
// bus   : slave side of alu_if (ALUControl/A/B in; ALUFlags/Result/ResultExtra out, one cycle later)
module alu_unit
    import alu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    alu_if.slave   bus
);

    alu_op_e          op;
    logic             is_sub;
    logic [WIDTH-1:0] b_add;
    logic [WIDTH:0]   sum;
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic [63:0]      product;

    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] ext_d;
    logic             c_d;
    logic             v_d;
    logic [3:0]       flags_d;

    assign op = alu_op_e'(bus.ALUControl);

    // Shared adder: SUB is A + ~B + 1, so carry out means "no borrow".
    assign is_sub = (op == ALU_SUB);
    assign b_add  = is_sub ? ~bus.B : bus.B;
    assign sum    = {1'b0, bus.A} + {1'b0, b_add} + {{WIDTH{1'b0}}, is_sub};

    // Only SMULL sign-extends; MUL's low word is identical either way.
    assign mul_a = {(op == ALU_SMULL) & bus.A[WIDTH-1], bus.A};
    assign mul_b = {(op == ALU_SMULL) & bus.B[WIDTH-1], bus.B};

    alu_mul64 u_mul (
        .a       (mul_a),
        .b       (mul_b),
        .product (product)
    );

    always_comb begin
        res_d = '0;
        ext_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                res_d = sum[WIDTH-1:0];
                c_d   = sum[WIDTH];
                // Overflow: operands agree in sign (ADD) or differ (SUB),
                // and the result sign departs from A.
                v_d   = ((bus.A[WIDTH-1] ^ bus.B[WIDTH-1]) == is_sub) &&
                        (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            ALU_AND: res_d = bus.A & bus.B;
            ALU_ORR: res_d = bus.A | bus.B;
            ALU_EOR: res_d = bus.A ^ bus.B;
            ALU_MUL: res_d = product[WIDTH-1:0];
            ALU_SMULL, ALU_UMULL: begin
                res_d = product[WIDTH-1:0];
                ext_d = product[63:WIDTH];
            end
            default: res_d = '0;
        endcase
    end

    // ext_d is zero outside the long multiplies, so one 64-bit zero test
    // serves every op; N comes from the top word only for the long forms.
    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_N] = (op == ALU_SMULL || op == ALU_UMULL) ? ext_d[WIDTH-1] : res_d[WIDTH-1];
        flags_d[FLAG_Z] = ({ext_d, res_d} == '0);
        flags_d[FLAG_C] = c_d;
        flags_d[FLAG_V] = v_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Result      <= '0;
            bus.ResultExtra <= '0;
            bus.ALUFlags    <= '0;
        end else begin
            bus.Result      <= res_d;
            bus.ResultExtra <= ext_d;
            bus.ALUFlags    <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - directed self-checking bench for alu_unit
module tb_alu_unit;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_if bus ();

    alu_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [31:0] e;
        logic [3:0]  f;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, "_res"},   {32'b0, bus.Result},      {32'b0, v.r});
        check({tag, "_ext"},   {32'b0, bus.ResultExtra}, {32'b0, v.e});
        check({tag, "_flags"}, {60'b0, bus.ALUFlags},    {60'b0, v.f});
    endtask

    task automatic drive(input vec_t v);
        bus.ALUControl = v.op;
        bus.A          = v.a;
        bus.B          = v.b;
    endtask

    initial begin
        vec_t v;
        total = 0;
        bad   = 0;

        //          op      a             b             result        extra         NZCV
        vecs.push_back('{3'b110, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFF, 4'b1000});
        vecs.push_back('{3'b111, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'h00000002, 4'b0000});
        vecs.push_back('{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        4'b1001});
        vecs.push_back('{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        4'b0110});
        vecs.push_back('{3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 32'h0,        4'b0111});
        vecs.push_back('{3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0,        4'b0110});
        vecs.push_back('{3'b001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'h0,        4'b1000});
        vecs.push_back('{3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0,        4'b0011});
        vecs.push_back('{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0,        4'b1000});
        vecs.push_back('{3'b011, 32'h0000000F, 32'h000000F0, 32'h000000FF, 32'h0,        4'b0000});
        vecs.push_back('{3'b100, 32'h12345678, 32'h12345678, 32'h00000000, 32'h0,        4'b0100});
        vecs.push_back('{3'b101, 32'h00010000, 32'h00010000, 32'h00000000, 32'h0,        4'b0100});
        vecs.push_back('{3'b101, 32'h00000007, 32'h00000006, 32'h0000002A, 32'h0,        4'b0000});
        vecs.push_back('{3'b101, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h0,        4'b1000});
        vecs.push_back('{3'b110, 32'h80000000, 32'h00000002, 32'h00000000, 32'hFFFFFFFF, 4'b1000});
        vecs.push_back('{3'b111, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 4'b0100});
        vecs.push_back('{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'b1000});

        // Hold reset across edges with a live op on the inputs.
        rst_n = 1'b0;
        drive(vecs[2]);
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset_hold", '{3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000});

        @(negedge clk);
        rst_n = 1'b1;

        // One op at a time: outputs one edge after operands.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_outputs($sformatf("v%0d", i), vecs[i]);
        end

        // Back-to-back: new operands every cycle, each result checked one edge later.
        @(negedge clk);
        drive(vecs[0]);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_outputs($sformatf("b2b%0d", i), vecs[i]);
            if (i < 5) drive(vecs[i + 1]);
        end

        // Asynchronous reset mid-cycle with nonzero outputs and random operands.
        @(negedge clk);
        drive(vecs[14]);
        @(posedge clk);
        #1;
        check_outputs("pre_async", vecs[14]);
        #2;
        bus.A = $urandom;
        bus.B = $urandom;
        rst_n = 1'b0;
        #1;
        check_outputs("async_reset", '{3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000});
        @(negedge clk);
        rst_n = 1'b1;
        v = vecs[8];
        drive(v);
        @(posedge clk);
        #1;
        check_outputs("post_reset", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
